// File: rtl/switch_pulse_scheduler.sv
// Drive-pulse sequencer for one latching photonic switch: turns SET/RESET target
// requests into non-overlapping, guarded, width-W pulses counted in en ticks.
module switch_pulse_scheduler #(
    parameter int WW          = 13,
    parameter int GUARD_TICKS = 4,
    parameter bit INIT_POS    = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          req_set,
    input  logic          req_reset,
    input  logic [WW-1:0] W,
    output logic          PWMset,
    output logic          PWMreset,
    output logic          position,
    output logic          busy,
    output logic          done,
    output logic          collision
);

    typedef enum logic [1:0] {IDLE, PULSE_SET, PULSE_RST, GUARD} state_t;

    localparam logic [WW-1:0] TIMER_ONE = WW'(1);
    localparam logic [WW-1:0] GUARD_LD  = WW'(GUARD_TICKS);

    state_t        state_q, state_d;
    logic [WW-1:0] timer_q, timer_d;
    logic          pos_q, pos_d;
    logic          pend_v_q, pend_v_d;
    logic          pend_q, pend_d;
    logic          set_q, set_d;
    logic          rst_q, rst_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          coll_q, coll_d;

    logic req_v, req_t, cand_v, cand_t;

    assign req_v = req_set ^ req_reset;
    assign req_t = req_set;

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        pos_d    = pos_q;
        pend_v_d = pend_v_q;
        pend_d   = pend_q;
        set_d    = set_q;
        rst_d    = rst_q;
        done_d   = 1'b0;
        coll_d   = req_set & req_reset;
        // A fresh request in IDLE is newer than anything pending, so it wins.
        cand_v   = req_v | pend_v_q;
        cand_t   = req_v ? req_t : pend_q;

        case (state_q)
            IDLE: begin
                pend_v_d = 1'b0;
                if (cand_v && (cand_t != pos_q)) begin
                    state_d = cand_t ? PULSE_SET : PULSE_RST;
                    set_d   = cand_t;
                    rst_d   = ~cand_t;
                    timer_d = (W == '0) ? TIMER_ONE : W;
                end
            end
            PULSE_SET, PULSE_RST: begin
                if (req_v) begin
                    pend_v_d = 1'b1;
                    pend_d   = req_t;
                end
                if (en) begin
                    if (timer_q == TIMER_ONE) begin
                        set_d  = 1'b0;
                        rst_d  = 1'b0;
                        pos_d  = (state_q == PULSE_SET);
                        done_d = 1'b1;
                        if (GUARD_TICKS == 0) begin
                            state_d = IDLE;
                            timer_d = '0;
                        end else begin
                            state_d = GUARD;
                            timer_d = GUARD_LD;
                        end
                    end else begin
                        timer_d = timer_q - TIMER_ONE;
                    end
                end
            end
            default: begin
                if (req_v) begin
                    pend_v_d = 1'b1;
                    pend_d   = req_t;
                end
                if (en) begin
                    if (timer_q == TIMER_ONE) begin
                        state_d = IDLE;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q - TIMER_ONE;
                    end
                end
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            pos_q    <= INIT_POS;
            pend_v_q <= 1'b0;
            pend_q   <= 1'b0;
            set_q    <= 1'b0;
            rst_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            coll_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            pos_q    <= pos_d;
            pend_v_q <= pend_v_d;
            pend_q   <= pend_d;
            set_q    <= set_d;
            rst_q    <= rst_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            coll_q   <= coll_d;
        end
    end

    assign PWMset    = set_q;
    assign PWMreset  = rst_q;
    assign position  = pos_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign collision = coll_q;

endmodule

// File: tb/tb_switch_pulse_scheduler.sv
// Bench for switch_pulse_scheduler: directed scenarios plus random traffic,
// compared every clock against a tick-counting behavioural model.
module tb_switch_pulse_scheduler;

    localparam int G = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b0;
    logic        req_set = 1'b0;
    logic        req_reset = 1'b0;
    logic [12:0] W = '0;
    logic        PWMset, PWMreset, position, busy, done, collision;

    switch_pulse_scheduler #(.WW(13), .GUARD_TICKS(G), .INIT_POS(1'b0)) dut (
        .clk(clk), .reset(reset), .en(en), .req_set(req_set), .req_reset(req_reset),
        .W(W), .PWMset(PWMset), .PWMreset(PWMreset), .position(position),
        .busy(busy), .done(done), .collision(collision)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc_n    = 0;

    // Model: phase 0 = idle, 1 = driving, 2 = guard; ticks counted upward.
    int m_phase, m_ticks, m_len;
    bit m_dir, m_pos, m_want_v, m_want, m_done, m_coll;

    int n_done, n_rst_pulses, n_rst_high, n_set_high;
    bit prev_rst;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_n);
    endtask

    task automatic model_reset();
        m_phase = 0; m_ticks = 0; m_len = 0; m_dir = 0; m_pos = 0;
        m_want_v = 0; m_want = 0; m_done = 0; m_coll = 0;
    endtask

    task automatic model_step(input bit rs, input bit rr, input bit e, input int w);
        bit one_req;
        one_req = rs ^ rr;
        m_coll  = rs & rr;
        m_done  = 0;
        if (m_phase == 0) begin
            if (one_req) begin m_want_v = 1; m_want = rs; end
            if (m_want_v && m_want != m_pos) begin
                m_phase = 1; m_dir = m_want; m_ticks = 0;
                m_len = (w == 0) ? 1 : w;
            end
            m_want_v = 0;
        end else begin
            if (one_req) begin m_want_v = 1; m_want = rs; end
            if (e) begin
                m_ticks++;
                if (m_phase == 1 && m_ticks == m_len) begin
                    m_pos = m_dir; m_done = 1; m_ticks = 0;
                    m_phase = (G == 0) ? 0 : 2;
                end else if (m_phase == 2 && m_ticks == G) begin
                    m_phase = 0; m_ticks = 0;
                end
            end
        end
    endtask

    function automatic logic [5:0] model_out();
        return {m_phase == 1 && m_dir, m_phase == 1 && !m_dir, m_pos,
                m_phase != 0, m_done, m_coll};
    endfunction

    task automatic compare_all(input string tag);
        check(tag, {PWMset, PWMreset, position, busy, done, collision}, model_out());
        check("overlap", PWMset & PWMreset, 0);
    endtask

    task automatic cyc(input bit rs, input bit rr, input bit e, input int w);
        req_set = rs; req_reset = rr; en = e; W = w[12:0];
        @(posedge clk);
        cyc_n++;
        model_step(rs, rr, e, w);
        #1;
        compare_all("cycle");
        if (done) n_done++;
        if (PWMreset && !prev_rst) n_rst_pulses++;
        if (PWMreset) n_rst_high++;
        if (PWMset) n_set_high++;
        prev_rst = PWMreset;
    endtask

    // mode 0: en every 4th clk, 1: en every clk, 2: random en
    task automatic idle_run(input int n, input int mode, input int w);
        for (int i = 0; i < n; i++) begin
            bit e;
            e = (mode == 0) ? ((cyc_n % 4) == 0) : (mode == 1) ? 1'b1 : bit'($urandom_range(0, 1));
            cyc(0, 0, e, w);
        end
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        #1;
        model_reset();
        compare_all("reset_async");
        @(posedge clk);
        cyc_n++;
        #1;
        compare_all("reset_hold");
        prev_rst = PWMreset;
        reset = 1'b1;
    endtask

    initial begin
        model_reset();
        prev_rst = 0;
        #2;
        compare_all("reset_state");
        @(posedge clk); #1;
        reset = 1'b1;

        // T1: single SET request, W=2, en every 4th clk
        n_done = 0; n_set_high = 0;
        cyc(1, 0, (cyc_n % 4) == 0, 2);
        check("t1_latency", PWMset, 1);
        idle_run(40, 0, 2);
        check("t1_pos", position, 1);
        check("t1_done", n_done, 1);

        // T2: redundant SET
        n_done = 0; n_set_high = 0;
        cyc(1, 0, 1, 3);
        idle_run(10, 1, 3);
        check("t2_no_pulse", n_set_high, 0);
        check("t2_no_done", n_done, 0);

        // T3: collision
        cyc(1, 1, 1, 3);
        check("t3_coll", collision, 1);
        cyc(0, 0, 1, 3);
        check("t3_coll_strobe", collision, 0);
        idle_run(5, 1, 3);

        // T4: move to 0, then SET with conflicting requests arriving mid-pulse
        cyc(0, 1, 1, 3);
        idle_run(15, 1, 3);
        check("t4_pre_pos", position, 0);
        cyc(1, 0, 1, 6);
        n_rst_pulses = 0;
        cyc(0, 1, 1, 6);
        cyc(1, 0, 1, 6);
        cyc(0, 1, 1, 6);
        idle_run(30, 1, 6);
        check("t4_one_rst_pulse", n_rst_pulses, 1);
        check("t4_pos", position, 0);

        // T5: W=0 gives one-tick pulse; W=8191 gives 8191-clk pulse
        n_set_high = 0;
        cyc(1, 0, 1, 0);
        idle_run(10, 1, 0);
        check("t5_w0_len", n_set_high, 1);
        n_rst_high = 0;
        cyc(0, 1, 1, 8191);
        idle_run(8200, 1, 0);
        check("t5_wmax_len", n_rst_high, 8191);
        check("t5_pos", position, 0);

        // T6: reset mid PULSE_RST
        cyc(1, 0, 1, 2);
        idle_run(12, 1, 2);
        cyc(0, 1, 1, 10);
        idle_run(3, 1, 10);
        check("t6_in_pulse", PWMreset, 1);
        apply_reset();
        check("t6_drive_low", PWMreset, 0);
        check("t6_pos_init", position, 0);
        n_set_high = 0;
        cyc(1, 0, 1, 2);
        idle_run(12, 1, 2);
        check("t6_resume", n_set_high, 2);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bit rs, rr, e;
            rs = ($urandom_range(0, 7) == 0);
            rr = ($urandom_range(0, 7) == 0);
            e  = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 599) == 0) apply_reset();
            else cyc(rs, rr, e, int'($urandom_range(0, 5)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
